skew_inbuf: RTL and testbench
=============================

# skew_inbuf

Multi-lane input buffer that feeds the edge of the systolic array. It holds one circular FIFO per array row and pops all lanes from a single broadcast read strobe. Lane `i` is delayed by `i` cycles so operands enter the array on the required diagonal wavefront. Any lane with no data outputs zero padding, and full/empty, occupancy and error flags are reported per lane.

## Interface
- `WORDLEN`, 8, data word width in bits
- `DEPTH`, 16, entries per lane; power of two, 2..256
- `LANES`, 4, number of lanes (array rows), 1..16
- `SKEW`, 1, 1 = lane `i` read delayed `i` cycles; 0 = all lanes aligned
- `clk`  in  1  single clock, rising edge
- `rstn`  in  1  reset, asynchronous assert, active-low
- `clear`  in  1  synchronous flush of all lanes and skew pipeline
- `wr_en`  in  1  write strobe
- `wr_lane`  in  $clog2(LANES) (min 1)  target lane of write
- `din`  in  WORDLEN  write data
- `rd_en`  in  1  broadcast read step (one array step)
- `dout`  out  LANES*WORDLEN  lane `i` at bits `[i*WORDLEN +: WORDLEN]`, registered
- `dout_valid`  out  LANES  lane word is real data (1) or zero padding (0)
- `full`  out  LANES  per-lane full
- `empty`  out  LANES  per-lane empty
- `count`  out  LANES*($clog2(DEPTH)+1)  per-lane occupancy
- `overflow`  out  1  sticky: write attempted to a full lane
- `underflow`  out  1  sticky: pop attempted on an empty lane

## Operation
- Per lane, use head/tail pointers of `$clog2(DEPTH)+1` bits with an extra wrap bit.
  - `empty` = pointers equal.
  - `full` = index bits equal and wrap bits differ.
  - `count` = tail − head, modulo 2^(ptr width).
- Write: if `wr_en` and `!full[wr_lane]`, store `din` at the tail and increment the tail.
  - If the lane is full, drop the word, leave the pointers unchanged and set `overflow`.
  - If `wr_lane >= LANES`, ignore the write and set `overflow`.
- Skew pipeline: `rd_en` feeds a shift register of depth `LANES-1`.
  - The pop strobe for lane `i` is `rd_en` delayed by `i*SKEW` cycles.
  - Lane 0 is never delayed.
- Pop on lane `i`:
  - If not empty: `dout` lane ← head word, `dout_valid[i]` ← 1, head increments.
  - If empty: `dout` lane ← 0, `dout_valid[i]` ← 0, `underflow` set.
- No pop on lane `i`: `dout` lane ← 0 and `dout_valid[i]` ← 0. Outputs are zero-padded every non-pop cycle.
- Same-lane write and pop in one cycle: both take effect and `count` is unchanged.
  - A pop on an empty lane does not see the same-cycle write (no bypass). It outputs padding, the write lands, and the lane ends with count 1.
- A write to lane `j` never disturbs pops on other lanes.
- `clear`, synchronous and taking priority over write and pop in the same cycle:
  - all pointers, the skew shift register, `dout`, `dout_valid`, `overflow` and `underflow` go to 0
  - storage contents are don't-care
- Sticky flags clear only on reset or `clear`.

## Timing
- Reset (`rstn` low, takes effect asynchronously):
  - `dout` = 0, `dout_valid` = 0, `full` = 0, `empty` = all 1s, `count` = 0, `overflow` = 0, `underflow` = 0
  - pointers and skew pipeline = 0
  - storage need not reset
- Reset deasserted mid-stream: all in-flight skewed pops are discarded and lanes restart empty.
- `full`, `empty` and `count` are combinational from the pointers and reflect edge `t` writes/pops after edge `t`.
- Write accepted at edge `t`: the word is poppable by a pop strobe at edge `t+1` or later.
- `rd_en` high in cycle `t`: lane `i` pops at edge `t+i*SKEW`, and `dout`/`dout_valid` lane `i` show the result in cycle `t+i*SKEW+1`.
- A continuous `rd_en` burst of N cycles gives each lane N consecutive pops, staggered by one cycle per lane.
- Throughput: one write and one broadcast step per cycle.

## Test plan
- Reset / flags: `rstn` low mid-burst → all outputs hold reset values; `empty` = 4'b1111 and `count` = 0 next cycle.
- Skewed drain:
  - Stimulus: LANES=4, write lane `i` with 0x10+i, 0x20+i, 0x30+i; then assert `rd_en` for 3 cycles from cycle `t`.
  - Response: lane 0 gives 0x10,0x20,0x30 in cycles t+1..t+3; lane 3 gives 0x13,0x23,0x33 in cycles t+4..t+6, with `dout_valid` high exactly there and zeros elsewhere.
- Full / overflow:
  - Stimulus: DEPTH=16, 17 writes to lane 2.
  - Response: `full[2]` is 1 after the 16th write; the 17th word is dropped and `overflow` = 1. Draining returns words 1..16 in order and `count[2]` goes 16→0.
- Underflow padding: `rd_en` with lane 1 empty → lane 1 `dout` = 0, `dout_valid[1]` = 0, `underflow` = 1; other lanes unaffected.
- Wrap-around / simultaneous:
  - Stimulus: write and pop lane 0 in every cycle for 40 cycles starting from count 1.
  - Response: data is in order across pointer wrap and `count[0]` stays at 1. A write plus pop on an empty lane → padding out, `count` = 1.
- Clear: assert `clear` with lanes half full and skewed pops in flight → next cycle all `empty`, `count` = 0, no `dout_valid` pulses afterwards, flags = 0.

Source files
------------

// File: rtl/skew_inbuf.sv
// Skewed multi-lane input buffer for the systolic array edge: one circular FIFO
// per row, broadcast pop strobe delayed one cycle per lane, zero padding when idle.

module skew_inbuf_lane #(
   parameter int WORDLEN = 8,
   parameter int DEPTH   = 16,
   localparam int AW     = $clog2(DEPTH),
   localparam int PW     = AW + 1
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               clear,
   input  logic               wr,
   input  logic               pop,
   input  logic [WORDLEN-1:0] din,
   output logic [WORDLEN-1:0] dout,
   output logic               dout_valid,
   output logic               full,
   output logic               empty,
   output logic [PW-1:0]      count
);
   logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
   logic [WORDLEN-1:0] dout_q, dout_d;
   logic               dout_valid_q, dout_valid_d;
   logic               wr_ok, pop_ok;
   logic [WORDLEN-1:0] mem [DEPTH];

   // Extra MSB on each pointer separates the full case from the empty case.
   assign empty  = (head_q == tail_q);
   assign full   = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
   assign count  = tail_q - head_q;
   assign wr_ok  = wr & ~full;
   assign pop_ok = pop & ~empty;

   always_comb begin
      head_d       = head_q;
      tail_d       = tail_q;
      dout_d       = '0;
      dout_valid_d = 1'b0;
      if (clear) begin
         head_d = '0;
         tail_d = '0;
      end else begin
         if (wr_ok) tail_d = tail_q + PW'(1);
         // Pop reads the pre-edge head, so a same-cycle write to an empty lane is not bypassed.
         if (pop_ok) begin
            head_d       = head_q + PW'(1);
            dout_d       = mem[head_q[AW-1:0]];
            dout_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_q       <= '0;
         tail_q       <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok && !clear) mem[tail_q[AW-1:0]] <= din;
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
endmodule

module skew_inbuf #(
   parameter int WORDLEN = 8,
   parameter int DEPTH   = 16,
   parameter int LANES   = 4,
   parameter int SKEW    = 1,
   localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1,
   localparam int PW     = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     clear,
   input  logic                     wr_en,
   input  logic [LW-1:0]            wr_lane,
   input  logic [WORDLEN-1:0]       din,
   input  logic                     rd_en,
   output logic [LANES*WORDLEN-1:0] dout,
   output logic [LANES-1:0]         dout_valid,
   output logic [LANES-1:0]         full,
   output logic [LANES-1:0]         empty,
   output logic [LANES*PW-1:0]      count,
   output logic                     overflow,
   output logic                     underflow
);
   logic [LANES-1:0]              wr_sel;
   logic [LANES-1:0]              pop;
   logic [LANES-1:0][WORDLEN-1:0] lane_dout;
   logic [LANES-1:0][PW-1:0]      lane_count;
   logic                          overflow_q, overflow_d;
   logic                          underflow_q, underflow_d;

   generate
      if (SKEW != 0 && LANES > 1) begin : g_skew
         // skew_q[k] is rd_en delayed k+1 cycles; lane k+1 pops on it.
         logic [LANES-2:0] skew_q, skew_d;
         always_comb begin
            skew_d = '0;
            if (!clear) begin
               skew_d[0] = rd_en;
               for (int k = 1; k < LANES - 1; k++) skew_d[k] = skew_q[k-1];
            end
         end
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) skew_q <= '0;
            else       skew_q <= skew_d;
         end
         assign pop = {skew_q, rd_en};
      end else begin : g_noskew
         assign pop = {LANES{rd_en}};
      end

      for (genvar i = 0; i < LANES; i++) begin : g_lane
         assign wr_sel[i] = wr_en && (wr_lane == LW'(i));
         skew_inbuf_lane #(.WORDLEN(WORDLEN), .DEPTH(DEPTH)) u_lane (
            .clk        (clk),
            .rstn       (rstn),
            .clear      (clear),
            .wr         (wr_sel[i]),
            .pop        (pop[i]),
            .din        (din),
            .dout       (lane_dout[i]),
            .dout_valid (dout_valid[i]),
            .full       (full[i]),
            .empty      (empty[i]),
            .count      (lane_count[i])
         );
      end
   endgenerate

   // A write matching no lane addresses a lane that does not exist.
   always_comb begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      if (!clear) begin
         overflow_d  = overflow_q | (wr_en & ~(|wr_sel)) | (|(wr_sel & full));
         underflow_d = underflow_q | (|(pop & empty));
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign dout      = lane_dout;
   assign count     = lane_count;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
endmodule

// File: tb/tb_skew_inbuf.sv
// Randomized and directed scoreboard bench for skew_inbuf against a queue-based lane model.

module tb_skew_inbuf;
   localparam int W  = 8;
   localparam int D  = 16;
   localparam int L  = 4;
   localparam int SK = 1;
   localparam int LW = 2;
   localparam int PW = 5;

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic           clear = 1'b0;
   logic           wr_en = 1'b0;
   logic [LW-1:0]  wr_lane = '0;
   logic [W-1:0]   din = '0;
   logic           rd_en = 1'b0;
   logic [L*W-1:0] dout;
   logic [L-1:0]   dout_valid, full, empty;
   logic [L*PW-1:0] count;
   logic           overflow, underflow;

   skew_inbuf #(.WORDLEN(W), .DEPTH(D), .LANES(L), .SKEW(SK)) dut (
      .clk(clk), .rstn(rstn), .clear(clear), .wr_en(wr_en), .wr_lane(wr_lane),
      .din(din), .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid),
      .full(full), .empty(empty), .count(count), .overflow(overflow),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [L*W-1:0]  dout;
      logic [L-1:0]    vld;
      logic [L*PW-1:0] cnt;
      logic [L-1:0]    full;
      logic [L-1:0]    empty;
      logic            ovf;
      logic            unf;
   } exp_t;

   exp_t expq[$];
   int   mq[L][$];
   bit   rdh[$];
   bit   m_ovf, m_unf;
   int   total = 0;
   int   bad = 0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
      end
   endfunction

   task automatic model_reset();
      for (int i = 0; i < L; i++) mq[i].delete();
      rdh.delete();
      for (int i = 0; i < L; i++) rdh.push_back(1'b0);
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // One array step: drive inputs, advance the model across the coming edge, queue expectation.
   task automatic step(input bit clr, input bit we, input int wl, input logic [W-1:0] d, input bit re);
      exp_t e;
      int   pre[L];
      int   sz;
      @(negedge clk);
      clear   = clr;
      wr_en   = we;
      wr_lane = wl[LW-1:0];
      din     = d;
      rd_en   = re;
      e = '0;
      rdh.push_front(re);
      rdh.pop_back();
      if (clr) begin
         for (int i = 0; i < L; i++) mq[i].delete();
         for (int i = 0; i < L; i++) rdh[i] = 1'b0;
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         for (int i = 0; i < L; i++) pre[i] = mq[i].size();
         for (int i = 0; i < L; i++) begin
            if (rdh[i*SK]) begin
               if (pre[i] > 0) begin
                  e.dout[i*W +: W] = W'(mq[i].pop_front());
                  e.vld[i] = 1'b1;
               end else m_unf = 1'b1;
            end
         end
         if (we) begin
            if (wl >= L || pre[wl] == D) m_ovf = 1'b1;
            else mq[wl].push_back(int'(d));
         end
      end
      for (int i = 0; i < L; i++) begin
         sz = mq[i].size();
         e.cnt[i*PW +: PW] = sz[PW-1:0];
         e.full[i]  = (sz == D);
         e.empty[i] = (sz == 0);
      end
      e.ovf = m_ovf;
      e.unf = m_unf;
      expq.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, '0, 0);
   endtask

   task automatic check_reset_vals();
      chk("rst_dout", 64'(dout), 64'd0);
      chk("rst_valid", 64'(dout_valid), 64'd0);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_empty", 64'(empty), 64'hF);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_unf", 64'(underflow), 64'd0);
   endtask

   // Asynchronous reset between edges, after the last queued expectation has been consumed.
   task automatic do_reset();
      @(posedge clk);
      #2;
      rstn  = 1'b0;
      clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_lane = '0; din = '0;
      #1;
      check_reset_vals();
      if (expq.size() != 0) begin
         bad++;
         $display("FAIL rst_queue: got %0d want 0", expq.size());
         expq.delete();
      end
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   exp_t me;
   always @(posedge clk) begin
      #1;
      if (expq.size() > 0) begin
         me = expq.pop_front();
         chk("dout", 64'(dout), 64'(me.dout));
         chk("dout_valid", 64'(dout_valid), 64'(me.vld));
         chk("count", 64'(count), 64'(me.cnt));
         chk("full", 64'(full), 64'(me.full));
         chk("empty", 64'(empty), 64'(me.empty));
         chk("overflow", 64'(overflow), 64'(me.ovf));
         chk("underflow", 64'(underflow), 64'(me.unf));
      end
   end

   initial begin
      model_reset();
      #3;
      check_reset_vals();
      @(negedge clk);
      rstn = 1'b1;
      idle(2);

      // skewed drain of three words per lane
      for (int k = 1; k <= 3; k++)
         for (int i = 0; i < L; i++) step(0, 1, i, W'(16*k + i), 0);
      for (int k = 0; k < 3; k++) step(0, 0, 0, '0, 1);
      idle(6);

      // fill lane 2 past full, then drain it
      step(1, 0, 0, '0, 0);
      for (int k = 1; k <= 17; k++) step(0, 1, 2, W'(k), 0);
      for (int k = 0; k < 18; k++) step(0, 0, 0, '0, 1);
      idle(4);

      // underflow on lane 1 while the others hold data
      step(1, 0, 0, '0, 0);
      step(0, 1, 0, 8'hA0, 0);
      step(0, 1, 2, 8'hA2, 0);
      step(0, 1, 3, 8'hA3, 0);
      step(0, 0, 0, '0, 1);
      idle(4);

      // write+pop lane 0 every cycle across pointer wrap
      step(1, 0, 0, '0, 0);
      step(0, 1, 0, 8'hC0, 0);
      for (int k = 0; k < 40; k++) step(0, 1, 0, W'(k), 1);
      idle(2);
      step(1, 0, 0, '0, 0);
      step(0, 1, 0, 8'h55, 1);
      idle(2);

      // clear with skewed pops in flight
      for (int k = 0; k < 8; k++)
         for (int i = 0; i < L; i++) step(0, 1, i, W'(8'h40 + k*4 + i), 0);
      step(0, 0, 0, '0, 1);
      step(0, 0, 0, '0, 1);
      step(1, 1, 1, 8'hEE, 1);
      idle(5);

      // reset mid-burst, then confirm lanes restart empty
      for (int i = 0; i < L; i++) step(0, 1, i, W'(8'h70 + i), 0);
      step(0, 0, 0, '0, 1);
      do_reset();
      idle(3);
      step(0, 1, 3, 8'h99, 0);
      step(0, 0, 0, '0, 1);
      idle(4);

      // randomized traffic
      for (int k = 0; k < 500; k++)
         step(($urandom % 60) == 0, ($urandom % 5) < 3, int'($urandom % L),
              W'($urandom), ($urandom % 2) == 0);
      idle(5);

      @(posedge clk);
      #3;
      if (expq.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", expq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
